// File: rtl/fht_seq_ctrl_if.sv
// rtl/fht_seq_ctrl_if.sv - control/address bundle between the FHT sequencer and its datapath
interface fht_seq_ctrl_if #(
    parameter int A_BIT = 8
) ();
    logic             iSTART;
    logic [3:0]       iN_LOG2;
    logic             iHOLD;
    logic             iABORT;
    logic [A_BIT-1:0] oADDR_RD_0;
    logic [A_BIT-1:0] oADDR_RD_1;
    logic [A_BIT-1:0] oADDR_WR_0;
    logic [A_BIT-1:0] oADDR_WR_1;
    logic [A_BIT-1:0] oADDR_COEF;
    logic             oWE_A;
    logic             oWE_B;
    logic [3:0]       oSTAGE;
    logic             oST_ZERO;
    logic             oST_LAST;
    logic [A_BIT-1:0] oSECTOR;
    logic             o2ND_PART_SUBSEC;
    logic             oSOURCE_DATA;
    logic             oSTAGE_DONE;
    logic             oRDY;
    logic             oERR;

    modport master (
        output iSTART, iN_LOG2, iHOLD, iABORT,
        input  oADDR_RD_0, oADDR_RD_1, oADDR_WR_0, oADDR_WR_1, oADDR_COEF,
        input  oWE_A, oWE_B, oSTAGE, oST_ZERO, oST_LAST, oSECTOR,
        input  o2ND_PART_SUBSEC, oSOURCE_DATA, oSTAGE_DONE, oRDY, oERR
    );

    modport slave (
        input  iSTART, iN_LOG2, iHOLD, iABORT,
        output oADDR_RD_0, oADDR_RD_1, oADDR_WR_0, oADDR_WR_1, oADDR_COEF,
        output oWE_A, oWE_B, oSTAGE, oST_ZERO, oST_LAST, oSECTOR,
        output o2ND_PART_SUBSEC, oSOURCE_DATA, oSTAGE_DONE, oRDY, oERR
    );
endinterface

// File: rtl/fht_seq_ctrl.sv
// rtl/fht_seq_ctrl.sv - FHT stage/address sequencer for a 4-bank in-place butterfly datapath
module fht_seq_ctrl #(
    parameter int N_MAX_LOG2 = 10,
    parameter int A_BIT      = N_MAX_LOG2 - 2,
    parameter int WR_LAT     = 2
) (
    input  logic          iCLK,
    input  logic          iRESET,
    fht_seq_ctrl_if.slave bus
);
    localparam int TW = A_BIT + 4;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_t;

    state_t           state_q;
    logic [3:0]       n_q;
    logic [3:0]       stage_q;
    logic [TW-1:0]    t_q;
    logic             src_q;
    logic             err_q;
    logic [A_BIT-1:0] coef_q;
    logic [A_BIT-1:0] pipe_addr_q [WR_LAT];
    logic             pipe_part_q [WR_LAT];

    logic [3:0]       divlog;
    logic [TW-1:0]    t_rd_last, t_end;
    logic             is_read, busy, is_zero, is_last, mid_stage;
    logic             active, done, we, start_ok, part_d;
    logic [A_BIT-1:0] t_a, mask_a, half_a, k_a, s_a, rd0_d, rd1_d, rev_d, base, wr0, wr1;

    always_comb begin
        // Sector length is 2^divlog: L on stages 0/1, halving each stage after, 1 on the last.
        divlog    = (stage_q == 4'd0) ? n_q - 4'd2 : n_q - 4'd1 - stage_q;
        t_rd_last = (TW'(1) << (n_q - 4'd2)) - TW'(1);
        t_end     = t_rd_last + TW'(WR_LAT);
        is_read   = (state_q == S_READ);
        busy      = (state_q != S_IDLE);
        is_zero   = (stage_q == 4'd0);
        is_last   = (stage_q == n_q - 4'd1);
        mid_stage = !is_zero && !is_last;
        active    = busy && !bus.iHOLD && !bus.iABORT;
        done      = (state_q == S_FLUSH) && (t_q == t_end) && active;
        we        = active && (t_q >= TW'(WR_LAT));
        start_ok  = bus.iSTART && (bus.iN_LOG2 >= 4'd4) && (bus.iN_LOG2 <= 4'(N_MAX_LOG2));

        t_a    = t_q[A_BIT-1:0];
        mask_a = ~({A_BIT{1'b1}} << divlog);
        half_a = mask_a ^ (mask_a >> 1);
        k_a    = t_a & mask_a;
        s_a    = is_read ? (t_a >> divlog) : '0;
        rd0_d  = is_read ? t_a : '0;
        // Partner mirrors k within the sector: s*div + (-k mod div).
        rd1_d  = (is_read && mid_stage && (s_a != '0))
               ? ((t_a & ~mask_a) + ((A_BIT'(0) - k_a) & mask_a)) : rd0_d;
        part_d = is_read && mid_stage && (k_a >= half_a);

        rev_d = '0;
        for (int i = 0; i < A_BIT; i++) begin
            rev_d[i] = s_a[A_BIT-1-i];
        end

        base = pipe_addr_q[WR_LAT-1];
        wr0  = base - ((mid_stage &&  pipe_part_q[WR_LAT-1]) ? half_a : '0);
        wr1  = base + ((mid_stage && !pipe_part_q[WR_LAT-1]) ? half_a : '0);
    end

    always_ff @(posedge iCLK) begin
        if (iRESET || bus.iABORT) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            t_q     <= '0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
            coef_q  <= '0;
            for (int i = 0; i < WR_LAT; i++) begin
                pipe_addr_q[i] <= '0;
                pipe_part_q[i] <= 1'b0;
            end
            if (iRESET) begin
                n_q <= 4'(N_MAX_LOG2);
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q <= S_READ;
                        n_q     <= bus.iN_LOG2;
                        stage_q <= '0;
                        t_q     <= '0;
                    end else if (bus.iSTART) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    if (!bus.iHOLD) begin
                        coef_q         <= is_zero ? '0 : rev_d;
                        pipe_addr_q[0] <= rd0_d;
                        pipe_part_q[0] <= part_d;
                        for (int i = 1; i < WR_LAT; i++) begin
                            pipe_addr_q[i] <= pipe_addr_q[i-1];
                            pipe_part_q[i] <= pipe_part_q[i-1];
                        end
                        if (state_q == S_READ) begin
                            t_q <= t_q + TW'(1);
                            if (t_q == t_rd_last) begin
                                state_q <= S_FLUSH;
                            end
                        end else if (t_q == t_end) begin
                            t_q <= '0;
                            if (is_last) begin
                                state_q <= S_IDLE;
                                stage_q <= '0;
                                src_q   <= 1'b0;
                            end else begin
                                state_q <= S_READ;
                                stage_q <= stage_q + 4'd1;
                                src_q   <= ~src_q;
                            end
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.oADDR_RD_0       = rd0_d;
    assign bus.oADDR_RD_1       = rd1_d;
    assign bus.oADDR_WR_0       = wr0;
    assign bus.oADDR_WR_1       = wr1;
    assign bus.oADDR_COEF       = coef_q;
    assign bus.oWE_A            = we &&  stage_q[0];
    assign bus.oWE_B            = we && !stage_q[0];
    assign bus.oSTAGE           = stage_q;
    assign bus.oST_ZERO         = busy && is_zero;
    assign bus.oST_LAST         = busy && is_last;
    assign bus.oSECTOR          = s_a;
    assign bus.o2ND_PART_SUBSEC = part_d;
    assign bus.oSOURCE_DATA     = src_q;
    assign bus.oSTAGE_DONE      = done;
    assign bus.oRDY             = (state_q == S_IDLE);
    assign bus.oERR             = err_q;
endmodule

// File: tb/tb_fht_seq_ctrl.sv
// tb/tb_fht_seq_ctrl.sv - randomized self-checking bench for fht_seq_ctrl
module tb_fht_seq_ctrl;
    localparam int NMAX = 10;
    localparam int AB   = 8;
    localparam int WL   = 2;

    logic iCLK   = 1'b0;
    logic iRESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fht_seq_ctrl_if #(.A_BIT(AB)) bus ();

    fht_seq_ctrl #(.N_MAX_LOG2(NMAX), .A_BIT(AB), .WR_LAT(WL)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    function automatic int f_div(input int n, input int st);
        int l;
        l = 1 << (n - 2);
        if (st <= 1) return l;
        return ((l >> (st - 1)) > 0) ? (l >> (st - 1)) : 1;
    endfunction

    function automatic int f_rd1(input int n, input int st, input int t);
        int d, k, s;
        d = f_div(n, st);
        k = t % d;
        s = t / d;
        if (st >= 1 && s >= 1 && st != n - 1) return s * d + (d - k) % d;
        return t;
    endfunction

    function automatic bit f_part(input int n, input int st, input int t);
        int d;
        d = f_div(n, st);
        if (st == 0 || st == n - 1) return 1'b0;
        return (t % d) >= (d / 2);
    endfunction

    function automatic int f_rev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < AB; i++) if (((v >> i) & 1) == 1) r = r | (1 << (AB - 1 - i));
        return r;
    endfunction

    function automatic logic [59:0] outs_vec();
        return {bus.oADDR_RD_0, bus.oADDR_RD_1, bus.oADDR_WR_0, bus.oADDR_WR_1, bus.oADDR_COEF,
                bus.oWE_A, bus.oWE_B, bus.oSTAGE, bus.oST_ZERO, bus.oST_LAST, bus.oSECTOR,
                bus.o2ND_PART_SUBSEC, bus.oSOURCE_DATA, bus.oSTAGE_DONE, bus.oERR};
    endfunction

    task automatic test_reset();
        iRESET = 1'b1;
        repeat (2) @(posedge iCLK);
        #1 iRESET = 1'b0;
        @(negedge iCLK);
        n_tests++;
        if (bus.oRDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", bus.oRDY); end
        n_tests++;
        if (outs_vec() !== 60'h0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", outs_vec()); end
        @(posedge iCLK); #1;
    endtask

    // Caller must be at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
    task automatic test_full_run(input int n, input int hold_pct, input bit rnd_start);
        int l, st, t, cyc, holds, dones, d, base;
        int we_cnt [16];
        bit hold, mid, bp, e_we, e_done, e_part;
        logic [AB-1:0] e_rd0, e_rd1, e_sec, e_coef, e_wr0, e_wr1;
        l = 1 << (n - 2);
        st = 0; t = 0; cyc = 0; holds = 0; dones = 0;
        for (int i = 0; i < 16; i++) we_cnt[i] = 0;
        n_tests++;
        if (bus.oRDY !== 1'b1) begin n_fail++; $display("FAIL run_pre_rdy n=%0d got=%b exp=1", n, bus.oRDY); end
        bus.iSTART  = 1'b1;
        bus.iN_LOG2 = 4'(n);
        @(posedge iCLK); #1;
        bus.iSTART = 1'b0;
        while (st < n && cyc < 20000) begin
            hold = ($urandom_range(0, 99) < hold_pct);
            bus.iHOLD = hold;
            if (rnd_start) begin
                bus.iSTART  = 1'($urandom_range(0, 1));
                bus.iN_LOG2 = 4'($urandom_range(0, 15));
            end
            @(negedge iCLK);
            d      = f_div(n, st);
            mid    = (st != 0) && (st != n - 1);
            e_rd0  = (t < l) ? AB'(t) : '0;
            e_rd1  = (t < l) ? AB'(f_rd1(n, st, t)) : '0;
            e_sec  = (t < l) ? AB'(t / d) : '0;
            e_part = (t < l) && f_part(n, st, t);
            e_coef = (t == 0 || st == 0 || t - 1 >= l) ? '0 : AB'(f_rev((t - 1) / d));
            e_we   = !hold && (t >= WL);
            e_done = !hold && (t == l - 1 + WL);
            n_tests++;
            if ({bus.oADDR_RD_0, bus.oADDR_RD_1, bus.oSECTOR, bus.oADDR_COEF} !== {e_rd0, e_rd1, e_sec, e_coef}) begin
                n_fail++;
                $display("FAIL rd_addr n=%0d st=%0d t=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", n, st, t,
                         bus.oADDR_RD_0, bus.oADDR_RD_1, bus.oSECTOR, bus.oADDR_COEF, e_rd0, e_rd1, e_sec, e_coef);
            end
            n_tests++;
            if ({bus.oWE_A, bus.oWE_B, bus.oSTAGE_DONE, bus.o2ND_PART_SUBSEC, bus.oSTAGE, bus.oSOURCE_DATA,
                 bus.oST_ZERO, bus.oST_LAST, bus.oRDY, bus.oERR} !==
                {e_we && (st % 2 == 1), e_we && (st % 2 == 0), e_done, e_part, 4'(st), st % 2 == 1,
                 st == 0, st == n - 1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL ctrl n=%0d st=%0d t=%0d hold=%b got we=%b%b done=%b part=%b stg=%0d src=%b z=%b l=%b rdy=%b err=%b",
                         n, st, t, hold, bus.oWE_A, bus.oWE_B, bus.oSTAGE_DONE, bus.o2ND_PART_SUBSEC, bus.oSTAGE,
                         bus.oSOURCE_DATA, bus.oST_ZERO, bus.oST_LAST, bus.oRDY, bus.oERR);
            end
            if (e_we) begin
                base  = t - WL;
                bp    = f_part(n, st, base);
                e_wr0 = AB'(base - ((mid && bp) ? d / 2 : 0));
                e_wr1 = AB'(base + ((mid && !bp) ? d / 2 : 0));
                n_tests++;
                if ({bus.oADDR_WR_0, bus.oADDR_WR_1} !== {e_wr0, e_wr1}) begin
                    n_fail++;
                    $display("FAIL wr_addr n=%0d st=%0d t=%0d got=%h/%h exp=%h/%h", n, st, t,
                             bus.oADDR_WR_0, bus.oADDR_WR_1, e_wr0, e_wr1);
                end
            end
            if (bus.oWE_A === 1'b1 || bus.oWE_B === 1'b1) we_cnt[st]++;
            if (bus.oSTAGE_DONE === 1'b1) dones++;
            @(posedge iCLK); #1;
            cyc++;
            if (hold) holds++;
            else if (t == l - 1 + WL) begin t = 0; st++; end
            else t++;
        end
        bus.iHOLD  = 1'b0;
        bus.iSTART = 1'b0;
        n_tests++;
        if (cyc !== n * (l + WL) + holds) begin n_fail++; $display("FAIL run_len n=%0d got=%0d exp=%0d", n, cyc, n * (l + WL) + holds); end
        n_tests++;
        if (dones !== n) begin n_fail++; $display("FAIL done_count n=%0d got=%0d exp=%0d", n, dones, n); end
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (we_cnt[i] !== l) begin n_fail++; $display("FAIL we_count n=%0d st=%0d got=%0d exp=%0d", n, i, we_cnt[i], l); end
        end
        n_tests++;
        if ({bus.oRDY, bus.oSOURCE_DATA} !== 2'b10) begin
            n_fail++;
            $display("FAIL run_end_rdy n=%0d got rdy=%b src=%b exp rdy=1 src=0", n, bus.oRDY, bus.oSOURCE_DATA);
        end
    endtask

    task automatic test_coef_point();
        bus.iSTART  = 1'b1;
        bus.iN_LOG2 = 4'd10;
        @(posedge iCLK); #1;
        bus.iSTART = 1'b0;
        repeat (2 * 258 + 130) @(posedge iCLK);
        @(negedge iCLK);
        n_tests++;
        if ({bus.oSTAGE, bus.oADDR_RD_0, bus.oADDR_RD_1} !== {4'd2, 8'd130, 8'd254}) begin
            n_fail++;
            $display("FAIL coef_point_rd got stg=%0d rd0=%0d rd1=%0d exp stg=2 rd0=130 rd1=254", bus.oSTAGE, bus.oADDR_RD_0, bus.oADDR_RD_1);
        end
        @(negedge iCLK);
        n_tests++;
        if (bus.oADDR_COEF !== 8'd128) begin n_fail++; $display("FAIL coef_point_coef got=%0d exp=128", bus.oADDR_COEF); end
        @(posedge iCLK); #1 bus.iABORT = 1'b1;
        @(posedge iCLK); #1 bus.iABORT = 1'b0;
    endtask

    task automatic test_abort();
        bus.iSTART  = 1'b1;
        bus.iN_LOG2 = 4'd6;
        @(posedge iCLK); #1;
        bus.iSTART = 1'b0;
        repeat (3 * 18 + 10) @(posedge iCLK);
        #1;
        bus.iABORT = 1'b1;
        bus.iHOLD  = 1'b1;
        bus.iSTART = 1'b1;
        @(negedge iCLK);
        n_tests++;
        if ({bus.oSTAGE, bus.oADDR_RD_0, bus.oSTAGE_DONE, bus.oWE_A} !== {4'd3, 8'd10, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_cycle got stg=%0d rd0=%0d done=%b we_a=%b exp 3/10/0/0", bus.oSTAGE, bus.oADDR_RD_0, bus.oSTAGE_DONE, bus.oWE_A);
        end
        @(posedge iCLK); #1;
        bus.iABORT = 1'b0;
        bus.iHOLD  = 1'b0;
        bus.iSTART = 1'b0;
        @(negedge iCLK);
        n_tests++;
        if ({bus.oRDY, outs_vec()} !== {1'b1, 60'h0}) begin
            n_fail++;
            $display("FAIL abort_outs got rdy=%b outs=%h exp rdy=1 outs=0", bus.oRDY, outs_vec());
        end
        @(posedge iCLK); #1;
        test_full_run(7, 0, 1'b0);
    endtask

    task automatic test_illegal();
        int bad [4];
        int we_seen;
        bad[0] = 3; bad[1] = 0; bad[2] = 11; bad[3] = 15;
        for (int i = 0; i < 4; i++) begin
            we_seen = 0;
            bus.iSTART  = 1'b1;
            bus.iN_LOG2 = 4'(bad[i]);
            @(posedge iCLK); #1;
            bus.iSTART = 1'b0;
            @(negedge iCLK);
            n_tests++;
            if ({bus.oERR, bus.oRDY} !== 2'b11) begin
                n_fail++;
                $display("FAIL illegal_err size=%0d got err=%b rdy=%b exp err=1 rdy=1", bad[i], bus.oERR, bus.oRDY);
            end
            repeat (6) begin
                @(negedge iCLK);
                if (bus.oWE_A !== 1'b0 || bus.oWE_B !== 1'b0 || bus.oERR !== 1'b0 || bus.oRDY !== 1'b1) we_seen++;
            end
            n_tests++;
            if (we_seen !== 0) begin n_fail++; $display("FAIL illegal_quiet size=%0d got=%0d bad cycles exp=0", bad[i], we_seen); end
            @(posedge iCLK); #1;
        end
    endtask

    task automatic test_reset_midrun();
        int we_seen;
        we_seen = 0;
        bus.iSTART  = 1'b1;
        bus.iN_LOG2 = 4'd6;
        @(posedge iCLK); #1;
        bus.iSTART = 1'b0;
        repeat (2 * 18 + 5) @(posedge iCLK);
        #1 iRESET = 1'b1;
        @(posedge iCLK); #1 iRESET = 1'b0;
        @(negedge iCLK);
        n_tests++;
        if ({bus.oRDY, outs_vec()} !== {1'b1, 60'h0}) begin
            n_fail++;
            $display("FAIL midreset_outs got rdy=%b outs=%h exp rdy=1 outs=0", bus.oRDY, outs_vec());
        end
        repeat (30) begin
            @(negedge iCLK);
            if (bus.oWE_A !== 1'b0 || bus.oWE_B !== 1'b0) we_seen++;
        end
        n_tests++;
        if (we_seen !== 0) begin n_fail++; $display("FAIL midreset_we got=%0d exp=0", we_seen); end
        @(posedge iCLK); #1;
        test_full_run(5, 0, 1'b0);
    endtask

    initial begin
        bus.iSTART  = 1'b0;
        bus.iN_LOG2 = 4'd0;
        bus.iHOLD   = 1'b0;
        bus.iABORT  = 1'b0;
        test_reset();
        test_full_run(4, 0, 1'b0);
        test_full_run(4, 0, 1'b0);
        test_full_run(6, 25, 1'b1);
        test_full_run(10, 10, 1'b1);
        test_full_run(7, 30, 1'b1);
        test_full_run(5, 0, 1'b1);
        test_coef_point();
        test_abort();
        test_illegal();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fht_seq_ctrl.md
FHT_SEQ_CTRL -- requirements
Module: fht_seq_ctrl

Interface
REQ-001 Parameter N_MAX_LOG2, default 10: largest supported transform, log2 points.
REQ-002 Parameter A_BIT, default N_MAX_LOG2-2: bank address width; 4 banks.
REQ-003 Parameter WR_LAT, default 2: read-to-write pipeline latency in cycles, legal 1..7.
REQ-004 iCLK  in  1  single clock; all logic on rising edge.
REQ-005 iRESET  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006 iSTART  in  1  start request, honoured only while oRDY=1.
REQ-007 iN_LOG2  in  4  transform size for this run, sampled at start; legal 4..N_MAX_LOG2.
REQ-008 iHOLD  in  1  stall: freezes all sequencing for the cycle.
REQ-009 iABORT  in  1  cancels the run.
REQ-010 oADDR_RD_0 / oADDR_RD_1  out  A_BIT each  direct / partner read address (banks 0,2 / 1,3).
REQ-011 oADDR_WR_0 / oADDR_WR_1  out  A_BIT each  write addresses (banks 0,1 / 2,3).
REQ-012 oADDR_COEF  out  A_BIT  coefficient ROM address.
REQ-013 oWE_A, oWE_B  out  1 each  write enable, bank set A / B.
REQ-014 oSTAGE  out  4  current stage; oST_ZERO, oST_LAST  out  1  stage flags.
REQ-015 oSECTOR  out  A_BIT  sector index; o2ND_PART_SUBSEC  out  1  second half of sector.
REQ-016 oSOURCE_DATA  out  1  ping-pong select, toggles per stage; oSTAGE_DONE  out  1  one-cycle pulse.
REQ-017 oRDY  out  1  idle; oERR  out  1  one-cycle illegal-size pulse.

Function
REQ-018 FSM states IDLE, READ, FLUSH; IDLE->READ on accepted start; READ->FLUSH when t=L-1; FLUSH->READ (next stage) or ->IDLE (last stage) when t=L-1+WR_LAT.
REQ-019 L=2^(n-2), n=latched iN_LOG2; stages 0..n-1; stage timer t runs 0..L-1+WR_LAT, reset to 0 at each stage start.
REQ-020 Accepted start: iSTART=1, oRDY=1, iN_LOG2 legal; oRDY=0, stage 0, t=0 next cycle.
REQ-021 Illegal iN_LOG2 with iSTART: oERR=1 next cycle, stay IDLE; iSTART while busy ignored.
REQ-022 Sector length div=L on stages 0 and 1, halved each later stage, floor 1; k = t mod div, s = t / div during READ.
REQ-023 oADDR_RD_0 = t during READ, 0 otherwise.
REQ-024 oADDR_RD_1 = s*div + ((div-k) mod div) on stages >=1 with s>=1; equals oADDR_RD_0 on stage 0, on sector 0, and on last stage.
REQ-025 o2ND_PART_SUBSEC = (k >= div/2) during READ; 0 on stages 0 and n-1.
REQ-026 Write pipeline: base write address = oADDR_RD_0 delayed WR_LAT active (non-held) cycles.
REQ-027 oADDR_WR_0 = base, minus div/2 when delayed 2nd-part flag=1; oADDR_WR_1 = base, plus div/2 when delayed flag=0; no offset on stages 0 and n-1; arithmetic modulo 2^A_BIT.
REQ-028 oWE_A (odd stages) / oWE_B (even stages) high exactly L cycles per stage, t=WR_LAT..L-1+WR_LAT; never both high.
REQ-029 oADDR_COEF = A_BIT-bit bit-reverse of s, delayed 1 cycle; 0 on stage 0.
REQ-030 oSOURCE_DATA toggles at each stage end; 0 in IDLE.
REQ-031 oSTAGE_DONE pulses on final FLUSH cycle of every stage.
REQ-032 iHOLD=1: t, s, stage, pipeline registers frozen; oWE_A/oWE_B forced 0 that cycle; addresses hold value.
REQ-033 iABORT=1 (priority over iHOLD, iSTART): IDLE next cycle, all outputs to reset values, no oSTAGE_DONE.
REQ-034 Last stage end: oRDY=1 the cycle after final oSTAGE_DONE; iSTART that cycle is accepted.

Reset
REQ-035 iRESET=1 overrides all inputs; next cycle: IDLE, oRDY=1, every other output 0, latched size = N_MAX_LOG2.
REQ-036 Reset mid-run discards the run; no further write enables.

Verification
REQ-037 WR_LAT=2, iN_LOG2=4, start -> 4 stages x 6 cycles, oRDY=1 at cycle 25, 4 oSTAGE_DONE pulses, oWE_B then oWE_A alternate, 4 WE cycles each.
REQ-038 iN_LOG2=10, stage 2 (div=128), t=130 -> oADDR_RD_0=130, oADDR_RD_1=254, oADDR_COEF=128 next cycle.
REQ-039 iN_LOG2=3 with start -> oERR pulse, oRDY stays 1, no WE.
REQ-040 iHOLD high 5 cycles mid stage 1 -> run 5 cycles longer, WE count per stage still L, address sequence unchanged.
REQ-041 iABORT at stage 3 t=10 -> oRDY=1, all outputs 0 next cycle; fresh start runs cleanly.
REQ-042 iRESET mid stage 2 -> reset values next cycle; iSTART with iN_LOG2=5 then completes 5 stages.
